sorted_packet_read_slave: RTL and testbench
===========================================

Name: sorted_packet_read_slave

Overview:
AXI4-Lite read-channel slave that stores sorted packets and returns them to the master. The write-side sorter pushes packets into two internal FIFOs: valid (header byte 0xA5) and invalid. The master drains those FIFOs and reads status through AR/R handshakes. Addressing uses the same 0x00/0x04 register style as the write side.

Parameters:
WIDTH, 32, packet/data width in bits (RDATA width).
DEPTH, 10, entries per FIFO; need not be a power of two.
CTRW, 4, counter/pointer width; DEPTH < 2**CTRW required.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
val_push  input  1  push request into valid FIFO
val_push_data  input  WIDTH  packet for valid FIFO
ival_push  input  1  push request into invalid FIFO
ival_push_data  input  WIDTH  packet for invalid FIFO
ARADDR  input  32  read address
ARVALID  input  1  master address valid
ARREADY  output  1  slave ready for address
RDATA  output  WIDTH  read data
RRESP  output  2  read response
RVALID  output  1  read data valid
RREADY  input  1  master ready for data
val_full, val_empty, ival_full, ival_empty  output  1 each  FIFO flags
val_fifo_ctr, ival_fifo_ctr  output  CTRW  FIFO occupancy
drop_ctr  output  16  pushes rejected because the target FIFO was full

Behaviour:
- Reset (rst==0 at a clk edge):
  - ARREADY=0, RVALID=0, RDATA=0, RRESP=00.
  - Both FIFOs emptied: pointers and counters 0, empty=1, full=0.
  - drop_ctr=0. Any in-flight transaction is abandoned.
- FSM has two states:
  - IDLE: ARREADY=1 (from the first edge after reset release). ARVALID&ARREADY latches the address, decodes it, loads RDATA/RRESP, performs any pop, and moves to RESP.
  - RESP: ARREADY=0, RVALID=1. RDATA/RRESP hold stable until RVALID&RREADY, then return to IDLE.
- Latency: RVALID rises on the edge that completes the AR handshake. There is at most one outstanding read. Back-to-back reads cost 2 cycles minimum.
- Address map (ARADDR[1:0] must be 00, else DECERR):
  - 0x00 STATUS: [0]val_empty [1]val_full [2]ival_empty [3]ival_full [15:8]val_fifo_ctr [23:16]ival_fifo_ctr (both zero-extended); other bits 0. RRESP=00.
  - 0x04 pop valid FIFO:
    - Non-empty: RDATA=head, RRESP=00, read pointer advances.
    - Empty: RDATA=0, RRESP=10 (SLVERR), no pop.
  - 0x08 pop invalid FIFO: same rules as 0x04, applied to the invalid FIFO.
  - 0x0C: RDATA={16'h0,drop_ctr}, RRESP=00.
  - Any other address: RDATA=0, RRESP=11 (DECERR).
- Pop happens at the AR handshake, not at the R handshake. Data is captured into the RDATA register, so later pushes cannot alter it.
- Push acceptance:
  - A push is accepted iff the FIFO count < DEPTH at the start of the cycle. Accepted data is written at the write pointer and the write pointer advances.
  - A rejected push increments drop_ctr. drop_ctr saturates at 16'hFFFF.
  - val_push and ival_push in the same cycle each count one drop if both are rejected (+2 total).
- Pointer wrap: when a pointer equals DEPTH-1 it goes to 0 on its next advance. Non-power-of-two wrap is mandatory.
- Push and pop on the same FIFO in one cycle:
  - Count is unchanged and both pointers advance.
  - If the FIFO was full, the push is still rejected because full is evaluated before the pop.
  - If the FIFO was empty, the pop returns SLVERR and the push is accepted.
- Counters and flags are registered and update on the same edge as the push/pop. full = (ctr==DEPTH), empty = (ctr==0).
- ARVALID held high during RESP is ignored until the FSM returns to IDLE.

Test Plan:
- Reset, then read 0x00 → RDATA=32'h0000_0005, RRESP=00, RVALID one cycle after the AR handshake.
- Push 0xA5000001 and 0xA5000002 to the valid FIFO; read 0x04 twice → 0xA5000001 then 0xA5000002, RRESP=00; third read → RDATA=0, RRESP=10, val_empty=1.
- Push 11 packets to the invalid FIFO → ival_fifo_ctr=10, ival_full=1; read 0x0C → RDATA=1.
- Fill the valid FIFO, pop 3, push 3, then pop 10 → FIFO order preserved across the DEPTH wrap; val_empty=1 at the end.
- Read 0x04 with RREADY held low 5 cycles while pushing a new packet → RDATA stays the original head; ARREADY=0 throughout.
- Reads at 0x10 and 0x06 → RRESP=11, RDATA=0. Asserting rst=0 during RESP → RVALID=0 and all counts 0 on the next edge.

Source files
------------

// File: rtl/sorted_packet_read_slave_if.sv
// AXI4-Lite read channel (AR/R) between a master and the sorted packet read slave.
interface sorted_packet_read_slave_if #(
    parameter int WIDTH = 32
);
    logic [31:0]      ARADDR;
    logic             ARVALID;
    logic             ARREADY;
    logic [WIDTH-1:0] RDATA;
    logic [1:0]       RRESP;
    logic             RVALID;
    logic             RREADY;

    modport slave (
        input  ARADDR, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output ARADDR, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/sorted_packet_read_slave.sv
// Read-side slave for the packet sorter: two packet FIFOs (valid/invalid) drained
// over AXI4-Lite reads, plus status and drop-counter registers.
module sorted_packet_read_slave #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10,
    parameter int CTRW  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                val_push,
    input  logic [WIDTH-1:0]    val_push_data,
    input  logic                ival_push,
    input  logic [WIDTH-1:0]    ival_push_data,
    sorted_packet_read_slave_if.slave bus,
    output logic                val_full,
    output logic                val_empty,
    output logic                ival_full,
    output logic                ival_empty,
    output logic [CTRW-1:0]     val_fifo_ctr,
    output logic [CTRW-1:0]     ival_fifo_ctr,
    output logic [15:0]         drop_ctr,
    output logic                state_dbg
);
    // Handshakes: a transfer happens on a rising edge where VALID and READY are both 1;
    // RDATA/RRESP stay stable while RVALID is high and RREADY is low.
    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    localparam logic [CTRW-1:0] DEPTH_C = CTRW'(DEPTH);
    localparam logic [CTRW-1:0] LAST_C  = CTRW'(DEPTH - 1);
    localparam logic [CTRW-1:0] ONE_C   = CTRW'(1);

    state_t           state_q, state_d;
    logic             arready_q;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;
    logic             ar_hs, r_hs;
    logic             pop_val, pop_ival;
    logic             val_push_ok, ival_push_ok;
    logic [31:0]      status;
    logic [16:0]      drop_sum;

    logic [WIDTH-1:0] val_mem  [DEPTH];
    logic [WIDTH-1:0] ival_mem [DEPTH];
    logic [CTRW-1:0]  val_wr, val_rd, ival_wr, ival_rd;

    function automatic logic [CTRW-1:0] adv(input logic [CTRW-1:0] p);
        return (p == LAST_C) ? '0 : p + ONE_C;
    endfunction

    assign ar_hs        = bus.ARVALID & arready_q;
    assign r_hs         = bus.RVALID & bus.RREADY;
    assign bus.ARREADY  = arready_q;
    assign bus.RVALID   = (state_q == RESP);
    assign bus.RDATA    = rdata_q;
    assign bus.RRESP    = rresp_q;
    assign state_dbg    = state_q;

    assign val_full     = (val_fifo_ctr == DEPTH_C);
    assign val_empty    = (val_fifo_ctr == '0);
    assign ival_full    = (ival_fifo_ctr == DEPTH_C);
    assign ival_empty   = (ival_fifo_ctr == '0);
    // Fullness is judged on the count before any same-cycle pop.
    assign val_push_ok  = val_push & ~val_full;
    assign ival_push_ok = ival_push & ~ival_full;

    assign status = {8'h00, 8'(ival_fifo_ctr), 8'(val_fifo_ctr), 4'h0,
                     ival_full, ival_empty, val_full, val_empty};

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ar_hs) state_d = RESP;
            RESP: if (r_hs)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d  = '0;
        rresp_d  = 2'b00;
        pop_val  = 1'b0;
        pop_ival = 1'b0;
        case (bus.ARADDR)
            32'h0000_0000: rdata_d = WIDTH'(status);
            32'h0000_0004: begin
                if (!val_empty) begin
                    rdata_d = val_mem[val_rd];
                    pop_val = ar_hs;
                end else begin
                    rresp_d = 2'b10;
                end
            end
            32'h0000_0008: begin
                if (!ival_empty) begin
                    rdata_d  = ival_mem[ival_rd];
                    pop_ival = ar_hs;
                end else begin
                    rresp_d = 2'b10;
                end
            end
            32'h0000_000C: rdata_d = WIDTH'({16'h0000, drop_ctr});
            default:       rresp_d = 2'b11;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            arready_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            arready_q <= (state_d == IDLE);
            if (ar_hs) begin
                rdata_q <= rdata_d;
                rresp_q <= rresp_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (val_push_ok)  val_mem[val_wr]   <= val_push_data;
        if (ival_push_ok) ival_mem[ival_wr] <= ival_push_data;
    end

    assign drop_sum = {1'b0, drop_ctr} + 17'(val_push & val_full) + 17'(ival_push & ival_full);

    always_ff @(posedge clk) begin
        if (!rst) begin
            val_wr <= '0; val_rd <= '0; val_fifo_ctr <= '0;
            ival_wr <= '0; ival_rd <= '0; ival_fifo_ctr <= '0;
            drop_ctr <= '0;
        end else begin
            if (val_push_ok)  val_wr  <= adv(val_wr);
            if (pop_val)      val_rd  <= adv(val_rd);
            if (ival_push_ok) ival_wr <= adv(ival_wr);
            if (pop_ival)     ival_rd <= adv(ival_rd);
            if (val_push_ok && !pop_val)       val_fifo_ctr  <= val_fifo_ctr + ONE_C;
            else if (!val_push_ok && pop_val)  val_fifo_ctr  <= val_fifo_ctr - ONE_C;
            if (ival_push_ok && !pop_ival)     ival_fifo_ctr <= ival_fifo_ctr + ONE_C;
            else if (!ival_push_ok && pop_ival) ival_fifo_ctr <= ival_fifo_ctr - ONE_C;
            drop_ctr <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
endmodule

// File: tb/tb_sorted_packet_read_slave.sv
// Directed plus randomized bench for sorted_packet_read_slave against a queue-based model.
module tb_sorted_packet_read_slave;
    localparam int WIDTH = 32;
    localparam int DEPTH = 10;
    localparam int CTRW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic val_push = 1'b0, ival_push = 1'b0;
    logic [WIDTH-1:0] val_push_data = '0, ival_push_data = '0;
    logic val_full, val_empty, ival_full, ival_empty, state_dbg;
    logic [CTRW-1:0] val_fifo_ctr, ival_fifo_ctr;
    logic [15:0] drop_ctr;

    sorted_packet_read_slave_if #(.WIDTH(WIDTH)) bus ();

    sorted_packet_read_slave #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CTRW(CTRW)) dut (
        .clk(clk), .rst(rst),
        .val_push(val_push), .val_push_data(val_push_data),
        .ival_push(ival_push), .ival_push_data(ival_push_data),
        .bus(bus),
        .val_full(val_full), .val_empty(val_empty),
        .ival_full(ival_full), .ival_empty(ival_empty),
        .val_fifo_ctr(val_fifo_ctr), .ival_fifo_ctr(ival_fifo_ctr),
        .drop_ctr(drop_ctr), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Reference model: packet queues, drop count and the observable read-channel registers.
    logic [WIDTH-1:0] val_q[$], ival_q[$];
    int   m_drops = 0;
    bit   m_arready = 0, m_rvalid = 0, m_post_reset = 1;
    logic [WIDTH-1:0] m_rdata = '0;
    logic [1:0]       m_rresp = 2'b00;
    bit   last_hs = 0;
    bit   rnd_push = 0;
    int   push_div = 4;
    int   checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("arready", 64'(bus.ARREADY), 64'(m_arready));
        chk("rvalid", 64'(bus.RVALID), 64'(m_rvalid));
        chk("rdata", 64'(bus.RDATA), 64'(m_rdata));
        chk("rresp", 64'(bus.RRESP), 64'(m_rresp));
        chk("val_ctr", 64'(val_fifo_ctr), 64'(val_q.size()));
        chk("ival_ctr", 64'(ival_fifo_ctr), 64'(ival_q.size()));
        chk("val_empty", 64'(val_empty), 64'(val_q.size() == 0));
        chk("val_full", 64'(val_full), 64'(val_q.size() == DEPTH));
        chk("ival_empty", 64'(ival_empty), 64'(ival_q.size() == 0));
        chk("ival_full", 64'(ival_full), 64'(ival_q.size() == DEPTH));
        chk("drop_ctr", 64'(drop_ctr), 64'(m_drops));
    endtask

    // One clock: evaluate the model on pre-edge inputs, advance the DUT, compare.
    task automatic tick();
        bit hs, rd, vacc, iacc, pv, pi;
        logic [WIDTH-1:0] d;
        logic [1:0] r;
        int vs, is;
        if (rnd_push) begin
            val_push       = ($urandom_range(0, push_div - 1) == 0);
            val_push_data  = {8'hA5, 24'($urandom)};
            ival_push      = ($urandom_range(0, push_div - 1) == 0);
            ival_push_data = $urandom;
        end
        if (!rst) begin
            @(posedge clk); #1;
            val_q.delete(); ival_q.delete();
            m_drops = 0; m_arready = 0; m_rvalid = 0; m_post_reset = 1;
            m_rdata = '0; m_rresp = 2'b00; last_hs = 0;
            check_outputs();
            return;
        end
        hs = bus.ARVALID && m_arready;
        rd = m_rvalid && bus.RREADY;
        vs = val_q.size(); is = ival_q.size();
        d = '0; r = 2'b00; pv = 0; pi = 0;
        if (hs) begin
            case (bus.ARADDR)
                32'h0: d = {8'h00, 8'(is), 8'(vs), 4'h0, 1'(is == DEPTH), 1'(is == 0),
                            1'(vs == DEPTH), 1'(vs == 0)};
                32'h4: if (vs > 0) begin d = val_q[0]; pv = 1; end else r = 2'b10;
                32'h8: if (is > 0) begin d = ival_q[0]; pi = 1; end else r = 2'b10;
                32'hC: d = 32'(m_drops);
                default: r = 2'b11;
            endcase
        end
        vacc = val_push && vs < DEPTH;
        iacc = ival_push && is < DEPTH;
        m_drops += int'(val_push && !vacc) + int'(ival_push && !iacc);
        if (m_drops > 65535) m_drops = 65535;
        if (pv) void'(val_q.pop_front());
        if (pi) void'(ival_q.pop_front());
        if (vacc) val_q.push_back(val_push_data);
        if (iacc) ival_q.push_back(ival_push_data);
        @(posedge clk); #1;
        if (m_post_reset) begin m_arready = 1; m_post_reset = 0; end
        if (hs) begin
            m_rvalid = 1; m_arready = 0; m_rdata = d; m_rresp = r;
        end else if (rd) begin
            m_rvalid = 0; m_arready = 1;
        end
        last_hs = hs;
        check_outputs();
    endtask

    task automatic push(input bit to_val, input logic [WIDTH-1:0] data);
        if (to_val) begin val_push = 1; val_push_data = data; end
        else        begin ival_push = 1; ival_push_data = data; end
        tick();
        val_push = 0; ival_push = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input int wait_cyc, input bit hold_ar,
                           input bit push_during);
        int n;
        bus.ARADDR = a; bus.ARVALID = 1; bus.RREADY = 0;
        n = 0; last_hs = 0;
        while (!last_hs && n < 20) begin tick(); n++; end
        chk("ar_handshake_seen", 64'(last_hs), 64'd1);
        if (!last_hs) begin bus.ARVALID = 0; return; end
        if (!hold_ar) bus.ARVALID = 0;
        for (int i = 0; i < wait_cyc; i++) begin
            if (push_during) begin val_push = 1; val_push_data = 32'hA5FF_FF00 + 32'(i); end
            tick();
        end
        val_push = 0;
        bus.RREADY = 1; tick();
        bus.RREADY = 0; bus.ARVALID = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        bus.ARADDR = '0; bus.ARVALID = 0; bus.RREADY = 0;
        rst = 0;
        tick(); tick();
        chk("reset_rdata", 64'(bus.RDATA), 64'h0);
        chk("reset_arready", 64'(bus.ARREADY), 64'h0);
        rst = 1;
        tick();

        // Status after reset: both FIFOs empty.
        do_read(32'h0, 0, 0, 0);
        chk("status_after_reset", 64'(bus.RDATA), 64'h5);
        chk("status_rresp", 64'(bus.RRESP), 64'h0);

        // Two valid pops, then an empty pop.
        push(1, 32'hA500_0001);
        push(1, 32'hA500_0002);
        do_read(32'h4, 0, 0, 0);
        chk("pop_first", 64'(bus.RDATA), 64'hA500_0001);
        do_read(32'h4, 1, 0, 0);
        chk("pop_second", 64'(bus.RDATA), 64'hA500_0002);
        do_read(32'h4, 0, 0, 0);
        chk("pop_empty_rdata", 64'(bus.RDATA), 64'h0);
        chk("pop_empty_rresp", 64'(bus.RRESP), 64'h2);
        chk("pop_empty_flag", 64'(val_empty), 64'h1);

        // Overfill the invalid FIFO by one.
        for (int i = 0; i < 11; i++) push(0, 32'h1000_0000 + 32'(i));
        chk("ival_ctr_full", 64'(ival_fifo_ctr), 64'd10);
        chk("ival_full_flag", 64'(ival_full), 64'h1);
        do_read(32'hC, 0, 0, 0);
        chk("drop_read", 64'(bus.RDATA), 64'h1);

        // Order across the non-power-of-two pointer wrap.
        for (int i = 0; i < 10; i++) push(1, 32'hA520_0000 + 32'(i));
        for (int i = 0; i < 3; i++) do_read(32'h4, 0, 0, 0);
        for (int i = 0; i < 3; i++) push(1, 32'hA530_0000 + 32'(i));
        for (int i = 0; i < 10; i++) do_read(32'h4, 0, i[0], 0);
        chk("wrap_last", 64'(bus.RDATA), 64'hA530_0002);
        chk("wrap_empty", 64'(val_empty), 64'h1);

        // Stalled response with pushes behind it, ARVALID held.
        push(1, 32'hA500_0077);
        do_read(32'h4, 5, 1, 1);
        chk("stall_head", 64'(bus.RDATA), 64'hA500_0077);

        // Decode errors.
        do_read(32'h10, 0, 0, 0);
        chk("decerr_10", 64'(bus.RRESP), 64'h3);
        do_read(32'h6, 2, 0, 0);
        chk("decerr_06", 64'(bus.RRESP), 64'h3);
        chk("decerr_06_data", 64'(bus.RDATA), 64'h0);

        // Reset while a response is pending.
        bus.ARADDR = 32'h8; bus.ARVALID = 1;
        last_hs = 0;
        for (int n = 0; n < 20 && !last_hs; n++) tick();
        bus.ARVALID = 0;
        rst = 0; tick();
        chk("rst_resp_rvalid", 64'(bus.RVALID), 64'h0);
        chk("rst_resp_ival", 64'(ival_fifo_ctr), 64'h0);
        rst = 1; tick();

        // Randomized traffic: fill-heavy phase then drain-heavy phase.
        rnd_push = 1;
        for (int i = 0; i < 300; i++) begin
            push_div = (i < 150) ? 3 : 16;
            case ($urandom_range(0, 7))
                0:       a = 32'h0;
                1, 2:    a = 32'h4;
                3, 4:    a = 32'h8;
                5:       a = 32'hC;
                6:       a = 32'($urandom_range(16, 255));
                default: a = 32'h4 + 32'($urandom_range(1, 3));
            endcase
            do_read(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rnd_push = 0; val_push = 0; ival_push = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
